fft_sequencer: RTL and testbench

- Control FSM that sequences the in-place radix-2 DIT butterfly datapath over a 64-point complex frame.
- Runs in three phases:
  - Bit-reversed sample load through a valid/ready stream.
  - LOG2N compute stages of N/2 butterflies each, one butterfly issued per cycle.
  - Natural-order unload through a valid/ready stream.
- Drives the register-file addresses, the twiddle index and the write strobes. Holds no sample data.

---
 rtl/fft_sequencer_if.sv | 39 +++
 rtl/fft_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fft_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sequencer_if.sv
// Interface bundle for the FFT sequencer.
// It carries the stream handshakes (start/busy/done, sample load and unload)
// and the register-file and twiddle addressing driven by the sequencer.
//   master : the frame source/sink and the datapath side
//   slave  : the sequencer itself
interface fft_sequencer_if #(
   parameter int LOG2N = 6
);
   logic             start;
   logic             busy;
   logic             done;
   logic             in_valid;
   logic             in_ready;
   logic             ld_en;
   logic [LOG2N-1:0] ld_addr;
   logic             bf_issue;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_idx;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;
   logic [2:0]       stage;
   logic             out_valid;
   logic             out_ready;
   logic [LOG2N-1:0] out_addr;

   modport master (
      output start, in_valid, out_ready,
      input  busy, done, in_ready, ld_en, ld_addr, bf_issue, rd_addr_a, rd_addr_b,
             tw_idx, wr_en, wr_addr_a, wr_addr_b, stage, out_valid, out_addr
   );

   modport slave (
      input  start, in_valid, out_ready,
      output busy, done, in_ready, ld_en, ld_addr, bf_issue, rd_addr_a, rd_addr_b,
             tw_idx, wr_en, wr_addr_a, wr_addr_b, stage, out_valid, out_addr
   );
endinterface

// File: rtl/fft_sequencer.sv
// Control FSM for an in-place radix-2 DIT FFT over an N-point complex frame.
// Loads samples in bit-reversed order, issues one butterfly per cycle for
// LOG2N stages, then unloads in natural order. Holds no sample data.
// All state updates on the falling edge of clk, matching the datapath registers.
// Ports:
//   clk : clock (falling-edge active)
//   rst : asynchronous active-low reset
//   bus : fft_sequencer_if.slave - start/busy/done, load stream, butterfly
//         read/write addressing and twiddle index, unload stream
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD    | accepting N samples, written to bit-reversed addresses
// S_COMPUTE | one butterfly issued per cycle, stage stg, index k
// S_DRAIN   | BF_LAT idle cycles so the last writes of a stage land
// S_UNLOAD  | presenting N samples in natural order
module fft_sequencer #(
   parameter int N      = 64,
   parameter int LOG2N  = 6,
   parameter int BF_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   fft_sequencer_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_UNLOAD  = 3'd4;

   localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
   localparam logic [LOG2N-2:0] K_LAST     = (LOG2N-1)'(N / 2 - 1);
   localparam logic [2:0]       STG_LAST   = 3'(LOG2N - 1);
   localparam int               DW         = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
   localparam logic [DW-1:0]    DRAIN_LOAD = DW'((BF_LAT > 0) ? BF_LAT - 1 : 0);

   logic [2:0]       state;
   logic [LOG2N-1:0] cnt;
   logic [2:0]       stg;
   logic [LOG2N-2:0] k;
   logic [DW-1:0]    drain_cnt;
   logic             done_q;

   logic             issue;
   logic [LOG2N-1:0] k_ext;
   logic [LOG2N-1:0] h;
   logic [LOG2N-1:0] h_mask;
   logic [LOG2N-1:0] a_raw;
   logic [LOG2N-2:0] tw_raw;
   logic [LOG2N-1:0] rd_a;
   logic [LOG2N-1:0] rd_b;
   logic [LOG2N-1:0] bitrev_cnt;

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         stg       <= '0;
         k         <= '0;
         drain_cnt <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // The done cycle is spent in IDLE; start is not honoured until the next one.
               if (bus.start && !done_q) begin
                  state <= S_LOAD;
                  cnt   <= '0;
               end
            end
            S_LOAD: begin
               if (bus.in_valid) begin
                  if (cnt == CNT_LAST) begin
                     state <= S_COMPUTE;
                     cnt   <= '0;
                     stg   <= '0;
                     k     <= '0;
                  end else begin
                     cnt <= cnt + LOG2N'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (k == K_LAST) begin
                  k <= '0;
                  if (BF_LAT > 0) begin
                     state     <= S_DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                  end else if (stg == STG_LAST) begin
                     state <= S_UNLOAD;
                     stg   <= '0;
                  end else begin
                     stg <= stg + 3'd1;
                  end
               end else begin
                  k <= k + (LOG2N-1)'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  if (stg == STG_LAST) begin
                     state <= S_UNLOAD;
                     stg   <= '0;
                  end else begin
                     state <= S_COMPUTE;
                     stg   <= stg + 3'd1;
                  end
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            S_UNLOAD: begin
               if (bus.out_ready) begin
                  if (cnt == CNT_LAST) begin
                     state  <= S_IDLE;
                     cnt    <= '0;
                     done_q <= 1'b1;
                  end else begin
                     cnt <= cnt + LOG2N'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Butterfly operand pair: insert a 0 at bit stg of k for the upper address;
   // the lower one is h above it. The twiddle scales k's low bits up to W_N.
   always_comb begin
      issue  = (state == S_COMPUTE);
      k_ext  = {1'b0, k};
      h      = LOG2N'(1) << stg;
      h_mask = h - LOG2N'(1);
      a_raw  = ((k_ext >> stg) << ({1'b0, stg} + 4'd1)) | (k_ext & h_mask);
      tw_raw = (k & h_mask[LOG2N-2:0]) << (4'(LOG2N - 1) - {1'b0, stg});
      rd_a   = issue ? a_raw : '0;
      rd_b   = issue ? (a_raw + h) : '0;
   end

   always_comb begin
      bitrev_cnt = '0;
      for (int i = 0; i < LOG2N; i++) begin
         bitrev_cnt[i] = cnt[LOG2N-1-i];
      end
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.in_ready  = (state == S_LOAD);
   assign bus.ld_en     = bus.in_valid && (state == S_LOAD);
   assign bus.ld_addr   = (state == S_LOAD) ? bitrev_cnt : '0;
   assign bus.bf_issue  = issue;
   assign bus.rd_addr_a = rd_a;
   assign bus.rd_addr_b = rd_b;
   assign bus.tw_idx    = issue ? tw_raw : '0;
   assign bus.stage     = stg;
   assign bus.out_valid = (state == S_UNLOAD);
   assign bus.out_addr  = (state == S_UNLOAD) ? cnt : '0;

   // Write-back delay line shifts in every state so a stage's last writes
   // retire during DRAIN; reset empties it, dropping any pending write.
   if (BF_LAT == 0) begin : g_nodly
      assign bus.wr_en     = issue;
      assign bus.wr_addr_a = rd_a;
      assign bus.wr_addr_b = rd_b;
   end else begin : g_dly
      logic [BF_LAT-1:0] v_q;
      logic [LOG2N-1:0]  a_q [BF_LAT];
      logic [LOG2N-1:0]  b_q [BF_LAT];

      always_ff @(negedge clk or negedge rst) begin
         if (!rst) begin
            v_q <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
               a_q[i] <= '0;
               b_q[i] <= '0;
            end
         end else begin
            v_q[0] <= issue;
            a_q[0] <= rd_a;
            b_q[0] <= rd_b;
            for (int i = 1; i < BF_LAT; i++) begin
               v_q[i] <= v_q[i-1];
               a_q[i] <= a_q[i-1];
               b_q[i] <= b_q[i-1];
            end
         end
      end

      assign bus.wr_en     = v_q[BF_LAT-1];
      assign bus.wr_addr_a = a_q[BF_LAT-1];
      assign bus.wr_addr_b = b_q[BF_LAT-1];
   end
endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: one instance with BF_LAT=1 and one with
// BF_LAT=2. Inputs change and outputs are sampled on the rising edge, half a
// period away from the falling edge the design acts on.
module tb_fft_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fft_sequencer_if #(.LOG2N(6)) bus1 ();
   fft_sequencer_if #(.LOG2N(6)) bus2 ();

   fft_sequencer #(.N(64), .LOG2N(6), .BF_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   fft_sequencer #(.N(64), .LOG2N(6), .BF_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       in_ready;
      logic       ld_en;
      logic [5:0] ld_addr;
      logic       iss;
      logic [5:0] a;
      logic [5:0] b;
      logic [4:0] tw;
      logic       wr;
      logic [5:0] wa;
      logic [5:0] wb;
      logic [2:0] st;
      logic       ov;
      logic [5:0] oa;
   } obs_t;

   obs_t obs1, obs2, o;
   logic [5:0] lut [5] = '{6'd0, 6'd32, 6'd16, 6'd48, 6'd8};

   always_comb obs1 = {bus1.busy, bus1.done, bus1.in_ready, bus1.ld_en, bus1.ld_addr,
                       bus1.bf_issue, bus1.rd_addr_a, bus1.rd_addr_b, bus1.tw_idx,
                       bus1.wr_en, bus1.wr_addr_a, bus1.wr_addr_b, bus1.stage,
                       bus1.out_valid, bus1.out_addr};
   always_comb obs2 = {bus2.busy, bus2.done, bus2.in_ready, bus2.ld_en, bus2.ld_addr,
                       bus2.bf_issue, bus2.rd_addr_a, bus2.rd_addr_b, bus2.tw_idx,
                       bus2.wr_en, bus2.wr_addr_a, bus2.wr_addr_b, bus2.stage,
                       bus2.out_valid, bus2.out_addr};

   function automatic logic [5:0] bitrev6(input int v);
      logic [5:0] x, r;
      x = 6'(v);
      for (int i = 0; i < 6; i++) r[i] = x[5-i];
      return r;
   endfunction

   // Expected butterfly outputs at observation c of an unstalled frame
   // (c=1 is the first sample after the edge that captured start).
   function automatic void model_at(input int c, input int lat, output logic iss,
                                    output logic [5:0] a, output logic [5:0] b,
                                    output logic [4:0] tw, output logic [2:0] st);
      int p, s, kk, h, lo;
      iss = 1'b0; a = '0; b = '0; tw = '0; st = '0;
      p = c - 65;
      if (p >= 0 && p < 6 * (32 + lat)) begin
         s  = p / (32 + lat);
         kk = p % (32 + lat);
         st = 3'(s);
         if (kk < 32) begin
            h   = 1 << s;
            lo  = kk % h;
            iss = 1'b1;
            a   = 6'((kk / h) * 2 * h + lo);
            b   = 6'((kk / h) * 2 * h + lo + h);
            tw  = 5'(lo * (32 / h));
         end
      end
   endfunction

   task automatic test_reset;
      rst = 1'b0;
      bus1.start = 0; bus1.in_valid = 0; bus1.out_ready = 0;
      bus2.start = 0; bus2.in_valid = 0; bus2.out_ready = 0;
      repeat (3) @(posedge clk);
      n_checks++;
      if (obs1 !== '0) begin
         n_fail++; $display("FAIL reset_dut1 got %h exp 0", obs1);
      end
      n_checks++;
      if (obs2 !== '0) begin
         n_fail++; $display("FAIL reset_dut2 got %h exp 0", obs2);
      end
      rst = 1'b1;
      @(posedge clk);
      n_checks++;
      if ({bus1.wr_en, bus1.busy, bus2.wr_en, bus2.busy} !== 4'b0) begin
         n_fail++;
         $display("FAIL post_reset wr/busy got %b exp 0000",
                  {bus1.wr_en, bus1.busy, bus2.wr_en, bus2.busy});
      end
   endtask

   task automatic test_frame(input int lat);
      int per, u0, dn, done_c;
      logic e_iss, d_iss, exp_ld, exp_ov;
      logic [5:0] e_a, e_b, d_a, d_b;
      logic [4:0] e_tw, d_tw;
      logic [2:0] e_st, d_st;
      per = 32 + lat; u0 = 65 + 6 * per; dn = u0 + 64; done_c = -1;
      if (lat == 1) begin
         bus1.in_valid = 1; bus1.out_ready = 1; bus1.start = 1;
      end else begin
         bus2.in_valid = 1; bus2.out_ready = 1; bus2.start = 1;
      end
      for (int c = 1; c <= dn + 1; c++) begin
         @(posedge clk);
         o = (lat == 1) ? obs1 : obs2;
         if (c == 1) begin
            bus1.start = 0; bus2.start = 0;
         end
         model_at(c, lat, e_iss, e_a, e_b, e_tw, e_st);
         model_at(c - lat, lat, d_iss, d_a, d_b, d_tw, d_st);
         exp_ld = (c <= 64);
         exp_ov = (c >= u0 && c < dn);
         if (o.done && done_c < 0) done_c = c;
         n_checks++;
         if ({o.in_ready, o.ld_en} !== {exp_ld, exp_ld}) begin
            n_fail++; $display("FAIL load_hs lat=%0d c=%0d got %b exp %b", lat, c,
                               {o.in_ready, o.ld_en}, {exp_ld, exp_ld});
         end
         if (exp_ld) begin
            n_checks++;
            if (o.ld_addr !== bitrev6(c - 1)) begin
               n_fail++; $display("FAIL ld_addr lat=%0d c=%0d got %0d exp %0d", lat, c,
                                  o.ld_addr, bitrev6(c - 1));
            end
         end
         if (c <= 5) begin
            n_checks++;
            if (o.ld_addr !== lut[c-1]) begin
               n_fail++; $display("FAIL ld_seq c=%0d got %0d exp %0d", c, o.ld_addr, lut[c-1]);
            end
         end
         n_checks++;
         if ({o.iss, o.a, o.b, o.tw} !== {e_iss, e_a, e_b, e_tw}) begin
            n_fail++; $display("FAIL bf_ops lat=%0d c=%0d got %b/%0d/%0d/%0d exp %b/%0d/%0d/%0d",
                               lat, c, o.iss, o.a, o.b, o.tw, e_iss, e_a, e_b, e_tw);
         end
         if (c >= 65 && c < u0) begin
            n_checks++;
            if (o.st !== e_st) begin
               n_fail++; $display("FAIL stage lat=%0d c=%0d got %0d exp %0d", lat, c, o.st, e_st);
            end
         end
         n_checks++;
         if ({o.wr, o.wa, o.wb} !== {d_iss, d_a, d_b}) begin
            n_fail++; $display("FAIL wr_back lat=%0d c=%0d got %b/%0d/%0d exp %b/%0d/%0d",
                               lat, c, o.wr, o.wa, o.wb, d_iss, d_a, d_b);
         end
         n_checks++;
         if (o.ov !== exp_ov || (exp_ov && o.oa !== 6'(c - u0))) begin
            n_fail++; $display("FAIL unload lat=%0d c=%0d got %b/%0d exp %b/%0d",
                               lat, c, o.ov, o.oa, exp_ov, c - u0);
         end
         n_checks++;
         if ({o.done, o.busy} !== {c == dn, c < dn}) begin
            n_fail++; $display("FAIL done_busy lat=%0d c=%0d got %b exp %b", lat, c,
                               {o.done, o.busy}, {c == dn, c < dn});
         end
         // Hand values straight from the index formulas.
         if (c == 66 || c == 65 + 2 * per + 5 || c == 65 + 5 * per + 31) begin
            n_checks++;
            if ((c == 66 && {o.a, o.b, o.tw} !== {6'd2, 6'd3, 5'd0}) ||
                (c == 65 + 2 * per + 5 && {o.a, o.b, o.tw} !== {6'd9, 6'd13, 5'd8}) ||
                (c == 65 + 5 * per + 31 && {o.a, o.b, o.tw} !== {6'd31, 6'd63, 5'd31})) begin
               n_fail++; $display("FAIL bf_spot lat=%0d c=%0d got %0d/%0d/%0d", lat, c,
                                  o.a, o.b, o.tw);
            end
         end
      end
      // Edges from the one that captured start up to the one that raised done.
      n_checks++;
      if (done_c - 1 !== 64 + 6 * (32 + lat) + 64) begin
         n_fail++; $display("FAIL frame_cycles lat=%0d got %0d exp %0d", lat, done_c - 1,
                            64 + 6 * (32 + lat) + 64);
      end
      bus1.in_valid = 0; bus1.out_ready = 0; bus2.in_valid = 0; bus2.out_ready = 0;
   endtask

   task automatic test_stalls;
      int   exp_cnt, guard;
      logic v;
      bus1.in_valid = 0; bus1.out_ready = 0; bus1.start = 1;
      @(posedge clk);
      bus1.start = 0;
      exp_cnt = 0; guard = 0;
      while (exp_cnt < 64 && guard < 1000) begin
         n_checks++;
         if (bus1.in_ready !== 1'b1 || bus1.ld_addr !== bitrev6(exp_cnt)) begin
            n_fail++; $display("FAIL stall_load got rdy=%b addr=%0d exp rdy=1 addr=%0d",
                               bus1.in_ready, bus1.ld_addr, bitrev6(exp_cnt));
         end
         v = ($urandom_range(0, 9) >= 3);
         bus1.in_valid = v;
         #1;
         n_checks++;
         if (bus1.ld_en !== v) begin
            n_fail++; $display("FAIL stall_ld_en got %b exp %b", bus1.ld_en, v);
         end
         if (v) exp_cnt++;
         @(posedge clk);
         guard++;
      end
      bus1.in_valid = 0;
      n_checks++;
      if (guard >= 1000 || bus1.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL stall_load_end got rdy=%b guard=%0d exp rdy=0", bus1.in_ready, guard);
      end
      guard = 0;
      while (!bus1.out_valid && guard < 400) begin
         @(posedge clk);
         guard++;
      end
      n_checks++;
      if (guard >= 400) begin
         n_fail++; $display("FAIL stall_wait_unload timeout got %0d cycles", guard);
      end
      exp_cnt = 0; guard = 0;
      while (exp_cnt < 64 && guard < 1000) begin
         n_checks++;
         if ({bus1.out_valid, bus1.out_addr, bus1.done} !== {1'b1, 6'(exp_cnt), 1'b0}) begin
            n_fail++; $display("FAIL stall_unload got v=%b addr=%0d done=%b exp v=1 addr=%0d done=0",
                               bus1.out_valid, bus1.out_addr, bus1.done, exp_cnt);
         end
         v = ($urandom_range(0, 9) >= 3);
         bus1.out_ready = v;
         if (v) exp_cnt++;
         @(posedge clk);
         guard++;
      end
      bus1.out_ready = 0;
      n_checks++;
      if ({bus1.done, bus1.busy, bus1.out_valid} !== 3'b100) begin
         n_fail++; $display("FAIL stall_done got %b exp 100", {bus1.done, bus1.busy, bus1.out_valid});
      end
      @(posedge clk);
      n_checks++;
      if (bus1.done !== 1'b0) begin
         n_fail++; $display("FAIL stall_done_pulse got %b exp 0", bus1.done);
      end
   endtask

   task automatic test_start_and_reset;
      logic e_iss, d_iss;
      logic [5:0] e_a, e_b, d_a, d_b;
      logic [4:0] e_tw, d_tw;
      logic [2:0] e_st, d_st;
      bus1.in_valid = 1; bus1.out_ready = 1; bus1.start = 1;
      for (int c = 1; c <= 174; c++) begin
         @(posedge clk);
         if (c == 1 || c == 101) bus1.start = 0;
         if (c == 100) bus1.start = 1;
         if (c >= 65) begin
            model_at(c, 1, e_iss, e_a, e_b, e_tw, e_st);
            n_checks++;
            if ({obs1.iss, obs1.a, obs1.b, obs1.tw, obs1.st} !== {e_iss, e_a, e_b, e_tw, e_st}) begin
               n_fail++; $display("FAIL start_in_compute c=%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                                  c, obs1.a, obs1.b, obs1.tw, obs1.st, e_a, e_b, e_tw, e_st);
            end
         end
      end
      model_at(173, 1, d_iss, d_a, d_b, d_tw, d_st);
      n_checks++;
      if ({obs1.a, obs1.b, obs1.tw, obs1.st, obs1.wr, obs1.wa} !== {6'd18, 6'd26, 5'd8, 3'd3, 1'b1, d_a}) begin
         n_fail++; $display("FAIL pre_reset got %0d/%0d/%0d/%0d wr=%b exp 18/26/8/3 wr=1",
                            obs1.a, obs1.b, obs1.tw, obs1.st, obs1.wr);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({obs1.busy, obs1.wr, obs1.iss, obs1.st} !== 6'b0) begin
         n_fail++; $display("FAIL mid_reset got busy=%b wr=%b iss=%b st=%0d exp all 0",
                            obs1.busy, obs1.wr, obs1.iss, obs1.st);
      end
      @(posedge clk);
      rst = 1'b1; bus1.start = 1;
      @(posedge clk);
      bus1.start = 0;
      n_checks++;
      if ({bus1.in_ready, bus1.ld_addr} !== {1'b1, 6'd0}) begin
         n_fail++; $display("FAIL fresh_load0 got rdy=%b addr=%0d exp rdy=1 addr=0", bus1.in_ready, bus1.ld_addr);
      end
      @(posedge clk);
      n_checks++;
      if (bus1.ld_addr !== 6'd32) begin
         n_fail++; $display("FAIL fresh_load1 got %0d exp 32", bus1.ld_addr);
      end
      rst = 1'b0; bus1.in_valid = 0; bus1.out_ready = 0;
      @(posedge clk);
      rst = 1'b1;
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulses = 0;
      bus1.in_valid = 1; bus1.out_ready = 1; bus1.start = 1;
      for (int c = 1; c <= 660; c++) begin
         @(posedge clk);
         if (c == 650) bus1.start = 0;
         if (bus1.done) pulses++;
         n_checks++;
         if (bus1.done !== (c == 327 || c == 655)) begin
            n_fail++; $display("FAIL b2b_done c=%0d got %b exp %b", c, bus1.done, (c == 327 || c == 655));
         end
         if (c == 328 || c == 329) begin
            n_checks++;
            if ({bus1.busy, bus1.in_ready, bus1.ld_addr} !== {c == 329, c == 329, 6'd0}) begin
               n_fail++; $display("FAIL b2b_restart c=%0d got busy=%b rdy=%b addr=%0d exp busy=%b",
                                  c, bus1.busy, bus1.in_ready, bus1.ld_addr, c == 329);
            end
         end
      end
      n_checks++;
      if (pulses != 2) begin
         n_fail++; $display("FAIL b2b_pulses got %0d exp 2", pulses);
      end
      bus1.in_valid = 0; bus1.out_ready = 0;
   endtask

   initial begin
      test_reset();
      test_frame(1);
      test_frame(2);
      test_stalls();
      test_start_and_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
